// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register.
// Imported by the RTL and the testbench.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_shift_counter.sv
// Shift-remaining counter: loads WIDTH on load, counts down per shift.
// Ports: clk, s_reset, en, load, shift in; empty, last (pulse) out.
module usr_shift_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic s_reset,
    input  logic en,
    input  logic load,
    input  logic shift,
    output logic empty,
    output logic last
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LOAD_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] ZERO     = '0;

    logic [CW-1:0] r_cnt;
    logic          r_empty;
    logic          r_last;

    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_cnt   <= ZERO;
            r_empty <= 1'b1;
            r_last  <= 1'b0;
        end else begin
            // last is a single-cycle pulse; only the 1->0 step raises it
            r_last <= 1'b0;
            if (en) begin
                if (load) begin
                    r_cnt   <= LOAD_CNT;
                    r_empty <= 1'b0;
                end else if (shift && r_cnt != ZERO) begin
                    r_cnt <= r_cnt - ONE;
                    if (r_cnt == ONE) begin
                        r_empty <= 1'b1;
                        r_last  <= 1'b1;
                    end
                end
            end
        end
    end

    assign empty = r_empty;
    assign last  = r_last;

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit hold/shift-right/shift-left/load register with shift counter.
// Ports: clk, s_reset, en, mode[1:0], rot, d, ser_in_msb/lsb in;
// q, ser_out_lsb/msb, empty, last out. USR_ROTATE_EN enables rotation.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             s_reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_lsb,
    output logic             ser_out_msb,
    output logic             empty,
    output logic             last
);

    logic [WIDTH-1:0] r_q;
    logic             w_msb_in;
    logic             w_lsb_in;
    logic             w_load;
    logic             w_shift;

`ifdef USR_ROTATE_EN
    // rotation feeds the bit leaving one end back into the other
    always_comb begin
        w_msb_in = ser_in_msb;
        w_lsb_in = ser_in_lsb;
        if (rot) begin
            w_msb_in = r_q[0];
            w_lsb_in = r_q[WIDTH-1];
        end
    end
`else
    logic w_rot_unused;
    assign w_rot_unused = rot;
    assign w_msb_in     = ser_in_msb;
    assign w_lsb_in     = ser_in_lsb;
`endif

    assign w_load  = (mode == MODE_LOAD);
    assign w_shift = (mode == MODE_SHR) || (mode == MODE_SHL);

    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_q <= RESET_VALUE;
        end else if (en) begin
            unique case (mode)
                MODE_SHR:  r_q <= {w_msb_in, r_q[WIDTH-1:1]};
                MODE_SHL:  r_q <= {r_q[WIDTH-2:0], w_lsb_in};
                MODE_LOAD: r_q <= d;
                default:   r_q <= r_q;
            endcase
        end
    end

    usr_shift_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .s_reset (s_reset),
        .en      (en),
        .load    (w_load),
        .shift   (w_shift),
        .empty   (empty),
        .last    (last)
    );

    assign q           = r_q;
    assign ser_out_lsb = r_q[0];
    assign ser_out_msb = r_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed scoreboard bench for universal_shift_reg (WIDTH=8, RESET_VALUE=A5).
// Expected values come from a behavioural model queued at drive time.
module tb_universal_shift_reg;
    import usr_pkg::*;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    typedef struct packed {
        logic [7:0] q;
        logic       empty;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       s_reset, en, rot, ser_in_msb, ser_in_lsb;
    logic [1:0] mode;
    logic [7:0] d;
    logic [7:0] q;
    logic       ser_out_lsb, ser_out_msb, empty, last;

    int checks   = 0;
    int failures = 0;

    exp_t       sb[$];
    logic [7:0] m_q     = RV;
    int         m_cnt   = 0;
    logic       m_empty = 1'b1;
    logic       m_last  = 1'b0;
    logic [7:0] bits;
    int         nlast;

    universal_shift_reg #(
        .WIDTH       (W),
        .RESET_VALUE (RV)
    ) dut (
        .clk         (clk),
        .s_reset     (s_reset),
        .en          (en),
        .mode        (mode),
        .rot         (rot),
        .d           (d),
        .ser_in_msb  (ser_in_msb),
        .ser_in_lsb  (ser_in_lsb),
        .q           (q),
        .ser_out_lsb (ser_out_lsb),
        .ser_out_msb (ser_out_msb),
        .empty       (empty),
        .last        (last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_shift();
        if (m_cnt > 0) begin
            m_last = (m_cnt == 1);
            m_cnt--;
            if (m_cnt == 0) m_empty = 1'b1;
        end
    endtask

    // drive one cycle, predict, wait for the edge, compare
    task automatic step(input logic rst, input logic e, input logic [1:0] m,
                        input logic r, input logic [7:0] dd,
                        input logic smsb, input logic slsb);
        logic mi, li;
        exp_t ex, got;
        s_reset = rst; en = e; mode = m; rot = r; d = dd;
        ser_in_msb = smsb; ser_in_lsb = slsb;
        mi = smsb;
        li = slsb;
`ifdef USR_ROTATE_EN
        if (r) begin
            mi = m_q[0];
            li = m_q[7];
        end
`endif
        m_last = 1'b0;
        if (rst) begin
            m_q = RV; m_cnt = 0; m_empty = 1'b1;
        end else if (e) begin
            case (m)
                MODE_SHR: begin m_q = {mi, m_q[7:1]}; model_shift(); end
                MODE_SHL: begin m_q = {m_q[6:0], li}; model_shift(); end
                MODE_LOAD: begin m_q = dd; m_cnt = W; m_empty = 1'b0; end
                default: ;
            endcase
        end
        ex.q = m_q; ex.empty = m_empty; ex.last = m_last;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("q", q, got.q);
        check("empty", empty, got.empty);
        check("last", last, got.last);
        check("ser_lsb", ser_out_lsb, got.q[0]);
        check("ser_msb", ser_out_msb, got.q[7]);
        if (last) nlast++;
    endtask

    initial begin
        s_reset = 1'b1; en = 1'b0; mode = MODE_HOLD; rot = 1'b0;
        d = '0; ser_in_msb = 1'b0; ser_in_lsb = 1'b0;
        @(posedge clk);
        #1;

        // 1 reset dominates a LOAD
        for (int i = 0; i < 3; i++) step(1, 1, MODE_LOAD, 0, 8'hFF, 0, 0);
        check("t1_q", q, 8'hA5);
        check("t1_empty", empty, 1);

        // 2 load + serialize right
        step(0, 1, MODE_LOAD, 0, 8'h81, 0, 0);
        nlast = 0;
        for (int i = 0; i < 8; i++) begin
            bits[i] = ser_out_lsb;
            step(0, 1, MODE_SHR, 0, 8'h00, 0, 0);
        end
        check("t2_bits", bits, 8'b1000_0001);
        check("t2_q", q, 8'h00);
        check("t2_last", last, 1);
        check("t2_nlast", nlast, 1);
        step(0, 1, MODE_HOLD, 0, 8'h00, 0, 0);
        check("t2_last_off", last, 0);

        // 3 deserialize left
        step(0, 1, MODE_LOAD, 0, 8'h00, 0, 0);
        bits = 8'b0100_1101;
        nlast = 0;
        for (int i = 0; i < 8; i++) step(0, 1, MODE_SHL, 0, 8'h00, 0, bits[i]);
        check("t3_q", q, 8'hB2);
        check("t3_nlast", nlast, 1);

        // 4 enable / hold stall the count
        step(0, 1, MODE_LOAD, 0, 8'h3C, 0, 0);
        nlast = 0;
        for (int i = 0; i < 3; i++) step(0, 1, MODE_SHR, 0, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, MODE_SHR, 0, 8'hFF, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 1, MODE_HOLD, 0, 8'hFF, 0, 0);
        check("t4_q_held", q, 8'hE7);
        check("t4_nlast_mid", nlast, 0);
        for (int i = 0; i < 5; i++) step(0, 1, MODE_SHR, 0, 8'h00, 0, 0);
        check("t4_nlast", nlast, 1);
        check("t4_last", last, 1);

        // 5 reload and reset mid-sequence
        nlast = 0;
        step(0, 1, MODE_LOAD, 0, 8'hF0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, MODE_SHL, 0, 8'h00, 0, 1);
        step(0, 1, MODE_LOAD, 0, 8'h5A, 0, 0);
        check("t5_reload_q", q, 8'h5A);
        check("t5_reload_empty", empty, 0);
        for (int i = 0; i < 2; i++) step(0, 1, MODE_SHR, 0, 8'h00, 0, 0);
        step(1, 1, MODE_SHR, 0, 8'h00, 0, 0);
        check("t5_rst_q", q, 8'hA5);
        check("t5_rst_empty", empty, 1);
        for (int i = 0; i < 10; i++) step(0, 1, MODE_SHR, 0, 8'h00, 1, 0);
        check("t5_nlast", nlast, 0);
        check("t5_q_sat", q, 8'hFF);
        check("t5_empty_sat", empty, 1);

        // 6 rotate request
        step(0, 1, MODE_LOAD, 0, 8'h81, 0, 0);
        nlast = 0;
        for (int i = 0; i < 8; i++) step(0, 1, MODE_SHR, 1, 8'h00, 0, 0);
`ifdef USR_ROTATE_EN
        check("t6_q", q, 8'h81);
`else
        check("t6_q", q, 8'h00);
`endif
        check("t6_last", last, 1);
        check("t6_nlast", nlast, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
